mccpu_hs: RTL and testbench

//   Parametrised successor of the multicycle MIPS core: the same FETCH/DECODE/EXEC/MEM/WB datapath,
//   but every memory access uses a req/rdy handshake, so instruction and data memory may insert

---
 rtl/mccpu_hs.sv | 190 +++++++++++++++++++
 tb/tb_mccpu_hs.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/mccpu_hs.sv
// Multicycle MIPS-subset core with req/rdy memory handshake.
// FETCH/DECODE/EXEC/MEM/WB sequencing; memory may stall any access.
module mccpu_hs #(
   parameter int          NREG     = 32,
   parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
   input  logic        clk,
   input  logic        rst,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   input  logic        mem_rdy,
   output logic [31:0] instr,
   output logic [31:0] PC,
   output logic        retire,
   output logic        illegal,
   input  logic [4:0]  reg_sel,
   output logic [31:0] reg_data
);
   localparam int RW = $clog2(NREG);

   typedef enum logic [2:0] {
      S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB
   } state_t;

   state_t      r_state, w_nxt;
   logic        r_run;
   logic [31:0] r_pc, r_ir, r_a, r_b, r_alu, r_mdr;
   logic        r_ill;
   logic [31:0] r_gpr [NREG];

   logic [5:0]    w_op, w_fn;
   logic [RW-1:0] w_rs, w_rt, w_rd, w_dbg, w_wa;
   logic [31:0]   w_simm, w_zimm, w_rsv, w_rtv, w_alu, w_wd;
   logic          w_rt_op, w_xfer, w_we, w_take, w_legal;
   logic w_addu, w_subu, w_and, w_or, w_slt, w_sll, w_srl, w_jr;
   logic w_addiu, w_ori, w_lui, w_slti, w_lw, w_sw;
   logic w_beq, w_bne, w_j, w_jal, w_alu_op, w_short;

   assign w_op   = r_ir[31:26];
   assign w_fn   = r_ir[5:0];
   assign w_rs   = r_ir[21 +: RW];
   assign w_rt   = r_ir[16 +: RW];
   assign w_rd   = r_ir[11 +: RW];
   assign w_dbg  = reg_sel[RW-1:0];
   assign w_simm = {{16{r_ir[15]}}, r_ir[15:0]};
   assign w_zimm = {16'b0, r_ir[15:0]};

   assign w_rt_op = (w_op == 6'h00);
   assign w_addu  = w_rt_op && (w_fn == 6'h21);
   assign w_subu  = w_rt_op && (w_fn == 6'h23);
   assign w_and   = w_rt_op && (w_fn == 6'h24);
   assign w_or    = w_rt_op && (w_fn == 6'h25);
   assign w_slt   = w_rt_op && (w_fn == 6'h2A);
   assign w_sll   = w_rt_op && (w_fn == 6'h00);
   assign w_srl   = w_rt_op && (w_fn == 6'h02);
   assign w_jr    = w_rt_op && (w_fn == 6'h08);
   assign w_addiu = (w_op == 6'h09);
   assign w_ori   = (w_op == 6'h0D);
   assign w_lui   = (w_op == 6'h0F);
   assign w_slti  = (w_op == 6'h0A);
   assign w_lw    = (w_op == 6'h23);
   assign w_sw    = (w_op == 6'h2B);
   assign w_beq   = (w_op == 6'h04);
   assign w_bne   = (w_op == 6'h05);
   assign w_j     = (w_op == 6'h02);
   assign w_jal   = (w_op == 6'h03);

   assign w_alu_op = w_addu | w_subu | w_and | w_or | w_slt
                   | w_sll | w_srl | w_addiu | w_ori | w_lui | w_slti;
   assign w_legal  = w_alu_op | w_jr | w_lw | w_sw
                   | w_beq | w_bne | w_j | w_jal;
   // Instructions that finish in DECODE (illegal ones retire as NOPs)
   assign w_short  = w_j | w_jal | w_jr | !w_legal;

   assign w_rsv    = (w_rs == '0) ? '0 : r_gpr[w_rs];
   assign w_rtv    = (w_rt == '0) ? '0 : r_gpr[w_rt];
   assign reg_data = (w_dbg == '0) ? '0 : r_gpr[w_dbg];
   assign w_take   = (w_beq && (r_a == r_b)) || (w_bne && (r_a != r_b));
   assign w_xfer   = mem_req && mem_rdy;

   always_comb begin
      w_alu = '0;
      unique case (1'b1)
         w_addu:  w_alu = r_a + r_b;
         w_subu:  w_alu = r_a - r_b;
         w_and:   w_alu = r_a & r_b;
         w_or:    w_alu = r_a | r_b;
         w_slt:   w_alu = {31'b0, $signed(r_a) < $signed(r_b)};
         w_sll:   w_alu = r_b << r_ir[10:6];
         w_srl:   w_alu = r_b >> r_ir[10:6];
         w_addiu: w_alu = r_a + w_simm;
         w_ori:   w_alu = r_a | w_zimm;
         w_lui:   w_alu = {r_ir[15:0], 16'b0};
         w_slti:  w_alu = {31'b0, $signed(r_a) < $signed(w_simm)};
         default: w_alu = '0;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= S_FETCH;
         r_run   <= 1'b0;
      end else begin
         r_state <= w_nxt;
         r_run   <= 1'b1;
      end
   end

   always_comb begin
      w_nxt = r_state;
      unique case (r_state)
         S_FETCH:  if (w_xfer) w_nxt = S_DECODE;
         S_DECODE: w_nxt = w_short ? S_FETCH : S_EXEC;
         S_EXEC: begin
            if (w_lw || w_sw)        w_nxt = S_MEM;
            else if (w_beq || w_bne) w_nxt = S_FETCH;
            else                     w_nxt = S_WB;
         end
         S_MEM:    if (w_xfer) w_nxt = w_sw ? S_FETCH : S_WB;
         S_WB:     w_nxt = S_FETCH;
         default:  w_nxt = S_FETCH;
      endcase
   end

   always_comb begin
      mem_req   = r_run && (r_state == S_FETCH || r_state == S_MEM);
      mem_we    = mem_req && (r_state == S_MEM) && w_sw;
      mem_addr  = (r_state == S_MEM) ? r_alu : r_pc;
      mem_addr[1:0] = 2'b00;
      mem_wdata = r_b;
      retire    = ((r_state == S_DECODE) && w_short)
               || ((r_state == S_EXEC) && (w_beq || w_bne))
               || ((r_state == S_MEM) && w_sw && w_xfer)
               || (r_state == S_WB);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_pc  <= RESET_PC;
         r_ir  <= '0;
         r_a   <= '0;
         r_b   <= '0;
         r_alu <= '0;
         r_mdr <= '0;
         r_ill <= 1'b0;
      end else begin
         unique case (r_state)
            S_FETCH: if (w_xfer) begin
               r_ir <= mem_rdata;
               r_pc <= r_pc + 32'd4;
            end
            S_DECODE: begin
               r_a   <= w_rsv;
               r_b   <= w_rtv;
               r_alu <= r_pc + (w_simm << 2);
               if (w_j || w_jal) r_pc <= {r_pc[31:28], r_ir[25:0], 2'b00};
               else if (w_jr)    r_pc <= w_rsv;
               if (!w_legal)     r_ill <= 1'b1;
            end
            S_EXEC: begin
               if (w_lw || w_sw)  r_alu <= r_a + w_simm;
               else if (w_alu_op) r_alu <= w_alu;
               else if (w_take)   r_pc  <= r_alu;
            end
            S_MEM: if (w_xfer && w_lw) r_mdr <= mem_rdata;
            default: ;
         endcase
      end
   end

   assign w_we = ((r_state == S_DECODE) && w_jal) || (r_state == S_WB);
   assign w_wa = (r_state == S_DECODE) ? {RW{1'b1}}
               : (w_rt_op ? w_rd : w_rt);
   assign w_wd = (r_state == S_DECODE) ? r_pc : (w_lw ? r_mdr : r_alu);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NREG; i++) r_gpr[i] <= '0;
      end else if (w_we && (w_wa != '0)) begin
         r_gpr[w_wa] <= w_wd;
      end
   end

   assign instr   = r_ir;
   assign PC      = r_pc;
   assign illegal = r_ill;
endmodule

// File: tb/tb_mccpu_hs.sv
// Bench for mccpu_hs: stalling memory model, program table and a
// retire-driven scoreboard checking latency, PC, registers and flags.
module tb_mccpu_hs;
   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        mem_req, mem_we, retire, illegal;
   logic [31:0] mem_addr, mem_wdata, instr, PC, reg_data;
   logic [31:0] mem_rdata = '0;
   logic        mem_rdy = 1'b0;
   logic [4:0]  reg_sel = '0;

   always #5 clk = ~clk;

   mccpu_hs #(.NREG(32), .RESET_PC(32'h0000_3000)) dut (
      .clk(clk), .rst(rst),
      .mem_req(mem_req), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_rdy(mem_rdy),
      .instr(instr), .PC(PC),
      .retire(retire), .illegal(illegal),
      .reg_sel(reg_sel), .reg_data(reg_data)
   );

   typedef struct {
      logic [31:0] addr;
      logic [31:0] word;
      int          lat;
      logic [4:0]  rg;
      logic [31:0] val;
      logic [31:0] npc;
      logic        ill;
      int          fst;
      int          mst;
   } vec_t;

   logic [31:0] mem [0:4095];
   vec_t tbl [$];
   vec_t sb  [$];
   int   stallq [$];
   int   n_chk = 0;
   int   n_fail = 0;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   function automatic logic [31:0] enc_r(input int rs, input int rt,
         input int rd, input int sh, input logic [5:0] fn);
      return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'(sh), fn};
   endfunction

   function automatic logic [31:0] enc_i(input logic [5:0] op,
         input int rs, input int rt, input logic [15:0] imm);
      return {op, 5'(rs), 5'(rt), imm};
   endfunction

   function automatic logic [31:0] enc_j(input logic [5:0] op,
         input logic [25:0] tgt);
      return {op, tgt};
   endfunction

   function automatic vec_t mk(input logic [31:0] a, input logic [31:0] w,
         input int lat, input int rg, input logic [31:0] val,
         input logic [31:0] npc, input logic ill,
         input int fst, input int mst);
      vec_t v;
      v.addr = a; v.word = w; v.lat = lat; v.rg = 5'(rg);
      v.val = val; v.npc = npc; v.ill = ill; v.fst = fst; v.mst = mst;
      return v;
   endfunction

   // Memory model: each access pops its wait-state count on its first cycle
   int stall = 0;
   bit busy = 1'b0;
   always @(posedge clk) begin
      #1;
      if (mem_req) begin
         if (!busy) begin
            busy  = 1'b1;
            stall = (stallq.size() > 0) ? stallq.pop_front() : 0;
         end
         if (stall > 0) begin
            mem_rdy = 1'b0;
            stall--;
         end else begin
            mem_rdy   = 1'b1;
            mem_rdata = mem[mem_addr[13:2]];
            busy      = 1'b0;
         end
      end else begin
         mem_rdy = 1'b0;
         busy    = 1'b0;
      end
   end

   int   cnt = 0;
   int   nwr = 0;
   bit   pend = 1'b0;
   vec_t cur;
   always @(negedge clk) begin
      if (pend) begin
         pend = 1'b0;
         chk($sformatf("pc@%h", cur.addr), PC, cur.npc);
         chk($sformatf("r%0d@%h", cur.rg, cur.addr), reg_data, cur.val);
         chk($sformatf("ill@%h", cur.addr), {31'b0, illegal}, {31'b0, cur.ill});
      end
      if (mem_req && mem_we && mem_rdy) begin
         nwr++;
         chk("wr_addr", mem_addr, 32'h8);
         chk("wr_data", mem_wdata, 32'h2);
         mem[mem_addr[13:2]] = mem_wdata;
      end
      if (!rst) cnt = 0;
      else if (cnt > 0 || mem_req) cnt++;
      if (rst && retire) begin
         if (sb.size() > 0) begin
            cur = sb.pop_front();
            chk($sformatf("lat@%h", cur.addr), 32'(cnt), 32'(cur.lat));
            reg_sel = cur.rg;
            pend = 1'b1;
         end
         cnt = 0;
      end
   end

   initial begin
      tbl.push_back(mk(32'h3000, enc_i(6'h09, 0, 1, 16'd5),      4, 1, 32'd5,        32'h3004, 0, 0, 0));
      tbl.push_back(mk(32'h3004, enc_i(6'h09, 0, 2, 16'hFFFD),   4, 2, 32'hFFFFFFFD, 32'h3008, 0, 0, 0));
      tbl.push_back(mk(32'h3008, enc_r(1, 2, 3, 0, 6'h21),       4, 3, 32'd2,        32'h300C, 0, 0, 0));
      tbl.push_back(mk(32'h300C, enc_r(2, 1, 4, 0, 6'h2A),       4, 4, 32'd1,        32'h3010, 0, 0, 0));
      tbl.push_back(mk(32'h3010, enc_i(6'h2B, 0, 3, 16'd8),      4, 3, 32'd2,        32'h3014, 0, 0, 0));
      tbl.push_back(mk(32'h3014, enc_i(6'h23, 0, 6, 16'd8),      5, 6, 32'd2,        32'h3018, 0, 0, 0));
      tbl.push_back(mk(32'h3018, enc_i(6'h23, 0, 5, 16'd12),    10, 5, 32'hCAFEBABE, 32'h301C, 0, 3, 2));
      tbl.push_back(mk(32'h301C, enc_i(6'h09, 0, 0, 16'd7),      4, 0, 32'd0,        32'h3020, 0, 0, 0));
      tbl.push_back(mk(32'h3020, enc_r(1, 2, 7, 0, 6'h23),       4, 7, 32'd8,        32'h3024, 0, 0, 0));
      tbl.push_back(mk(32'h3024, enc_i(6'h0D, 1, 8, 16'hF0F0),   4, 8, 32'h0000F0F5, 32'h3028, 0, 0, 0));
      tbl.push_back(mk(32'h3028, enc_i(6'h0F, 0, 9, 16'h8001),   4, 9, 32'h80010000, 32'h302C, 0, 0, 0));
      tbl.push_back(mk(32'h302C, enc_i(6'h0A, 2, 10, 16'hFFFE),  4, 10, 32'd1,       32'h3030, 0, 0, 0));
      tbl.push_back(mk(32'h3030, enc_r(0, 1, 11, 4, 6'h00),      4, 11, 32'h50,      32'h3034, 0, 0, 0));
      tbl.push_back(mk(32'h3034, enc_r(0, 9, 12, 8, 6'h02),      4, 12, 32'h00800100, 32'h3038, 0, 0, 0));
      tbl.push_back(mk(32'h3038, enc_r(8, 11, 13, 0, 6'h24),     4, 13, 32'h50,      32'h303C, 0, 0, 0));
      tbl.push_back(mk(32'h303C, enc_r(1, 11, 14, 0, 6'h25),     4, 14, 32'h55,      32'h3040, 0, 0, 0));
      tbl.push_back(mk(32'h3040, enc_r(3, 3, 3, 0, 6'h21),       4, 3, 32'd4,        32'h3044, 0, 0, 0));
      tbl.push_back(mk(32'h3044, enc_i(6'h04, 1, 1, 16'd2),      3, 0, 32'd0,        32'h3050, 0, 0, 0));
      tbl.push_back(mk(32'h3050, enc_i(6'h04, 1, 2, 16'd5),      3, 0, 32'd0,        32'h3054, 0, 0, 0));
      tbl.push_back(mk(32'h3054, enc_i(6'h05, 1, 2, 16'd1),      3, 0, 32'd0,        32'h305C, 0, 0, 0));
      tbl.push_back(mk(32'h305C, enc_i(6'h05, 1, 1, 16'd1),      3, 0, 32'd0,        32'h3060, 0, 0, 0));
      tbl.push_back(mk(32'h3060, enc_j(6'h02, 26'h0000C20),      2, 0, 32'd0,        32'h3080, 0, 0, 0));
      tbl.push_back(mk(32'h3080, enc_j(6'h03, 26'h0000C30),      2, 31, 32'h3084,    32'h30C0, 0, 0, 0));
      tbl.push_back(mk(32'h30C0, enc_r(31, 0, 0, 0, 6'h08),      2, 31, 32'h3084,    32'h3084, 0, 0, 0));
      tbl.push_back(mk(32'h3084, 32'hFC00_0000,                  2, 3, 32'd4,        32'h3088, 1, 0, 0));
      tbl.push_back(mk(32'h3088, enc_i(6'h09, 0, 16, 16'd1),     4, 16, 32'd1,       32'h308C, 1, 0, 0));
      tbl.push_back(mk(32'h308C, enc_r(2, 1, 17, 0, 6'h23),      4, 17, 32'hFFFFFFF8, 32'h3090, 1, 0, 0));
      tbl.push_back(mk(32'h3090, enc_i(6'h23, 0, 18, 16'd9),     5, 18, 32'd2,       32'h3094, 1, 0, 0));

      for (int i = 0; i < 4096; i++) mem[i] = '0;
      mem[3] = 32'hCAFEBABE;
      mem[32'h3048 >> 2] = enc_i(6'h09, 0, 15, 16'h0BAD);
      mem[32'h304C >> 2] = enc_i(6'h09, 0, 15, 16'h0BAD);
      mem[32'h3058 >> 2] = enc_i(6'h09, 0, 15, 16'h0BAD);
      // This first entry belongs to the fetch abandoned by the mid-fetch reset
      stallq.push_back(5);
      for (int i = 0; i < tbl.size(); i++) begin
         mem[tbl[i].addr[13:2]] = tbl[i].word;
         sb.push_back(tbl[i]);
         stallq.push_back(tbl[i].fst);
         if (tbl[i].word[31:26] == 6'h23 || tbl[i].word[31:26] == 6'h2B)
            stallq.push_back(tbl[i].mst);
      end

      repeat (2) @(posedge clk);
      #1;
      chk("rst_req", {31'b0, mem_req}, 32'd0);
      chk("rst_pc", PC, 32'h3000);
      chk("rst_ir", instr, 32'd0);
      chk("rst_ret", {31'b0, retire}, 32'd0);
      chk("rst_ill", {31'b0, illegal}, 32'd0);

      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("rel_req0", {31'b0, mem_req}, 32'd0);
      @(posedge clk);
      #2;
      chk("rel_req1", {31'b0, mem_req}, 32'd1);
      chk("rel_addr", mem_addr, 32'h3000);
      @(posedge clk);
      @(posedge clk);
      #3;
      chk("mid_req", {31'b0, mem_req}, 32'd1);
      rst = 1'b0;
      #1;
      chk("abort_req", {31'b0, mem_req}, 32'd0);
      chk("abort_pc", PC, 32'h3000);
      repeat (2) @(negedge clk);
      rst = 1'b1;

      for (int c = 0; c < 3000 && (sb.size() > 0 || pend); c++)
         @(posedge clk);
      if (sb.size() > 0 || pend) begin
         n_chk++;
         n_fail++;
         $display("FAIL timeout: %0d retires outstanding, want 0", sb.size());
      end
      @(negedge clk);
      chk("n_writes", 32'(nwr), 32'd1);
      chk("final_ill", {31'b0, illegal}, 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end
endmodule
